sliding_mask_gen: RTL and testbench

SLIDING_MASK_GEN -- requirements
Module: sliding_mask_gen

---
 rtl/sliding_mask_gen.sv | 193 +++++++++++++++++++
 tb/tb_sliding_mask_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sliding_mask_gen.sv
// Streams a binary mask whose rows repeat a short pattern, each row shifted
// left or right by a fixed phase step relative to the row above.
module sliding_mask_gen #(
    parameter int IMG_W   = 300,
    parameter int IMG_H   = 300,
    parameter int PAT_MAX = 32,
    parameter int LANES   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic                       cfg_load,
    input  logic [PAT_MAX-1:0]         cfg_pattern,
    input  logic [$clog2(PAT_MAX):0]   cfg_len,
    input  logic [$clog2(PAT_MAX)-1:0] cfg_step,
    input  logic                       cfg_dir,
    input  logic                       start,
    input  logic                       abort,
    output logic [LANES-1:0]           m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_eol,
    output logic                       m_eof,
    output logic                       busy,
    output logic                       done
);

    localparam int LW = $clog2(PAT_MAX) + 1;
    localparam int SW = $clog2(PAT_MAX);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - LANES);
    localparam logic [XW-1:0] X_STEP = XW'(LANES);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam bit ONE_BEAT_ROW = (IMG_W == LANES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state;
    logic [PAT_MAX-1:0] pat_q;
    logic [LW-1:0]      len_q;
    logic [SW-1:0]      step_q;
    logic               dir_q;
    logic [XW-1:0]      x0_q;
    logic [YW-1:0]      y_q;
    logic [SW-1:0]      p_q;
    logic [SW-1:0]      beat_end_q;

    logic [LW-1:0]      len_c;
    logic [SW-1:0]      step_c;
    logic               take_cfg;
    logic [PAT_MAX-1:0] sel_pat;
    logic [LW-1:0]      sel_len;
    logic [SW-1:0]      p_next;
    logic [SW-1:0]      nxt_start;
    logic [LANES-1:0]   beat_data;
    logic [SW-1:0]      beat_end;
    logic [LW-1:0]      phase_acc;
    logic [LW-1:0]      ix;

    always_comb begin
        len_c = cfg_len;
        if (cfg_len == '0)
            len_c = LW'(1);
        else if (cfg_len > LW'(PAT_MAX))
            len_c = LW'(PAT_MAX);
        step_c = ({1'b0, cfg_step} >= len_c) ? '0 : cfg_step;
    end

    // A cfg_load coinciding with start must already shape the first beat.
    assign take_cfg = (state == S_IDLE) && cfg_load;
    assign sel_pat  = take_cfg ? cfg_pattern : pat_q;
    assign sel_len  = take_cfg ? len_c : len_q;

    always_comb begin
        phase_acc = '0;
        if (!dir_q) begin
            phase_acc = {1'b0, p_q} + {1'b0, step_q};
            if (phase_acc >= len_q)
                phase_acc = phase_acc - len_q;
        end else if (p_q >= step_q) begin
            phase_acc = {1'b0, p_q} - {1'b0, step_q};
        end else begin
            phase_acc = {1'b0, p_q} + len_q - {1'b0, step_q};
        end
        p_next = phase_acc[SW-1:0];
    end

    always_comb begin
        if (state != S_RUN)
            nxt_start = '0;
        else if (m_eol)
            nxt_start = p_next;
        else
            nxt_start = beat_end_q;
    end

    // Walk the pattern index across the lanes, wrapping at len with a compare
    // instead of a modulo; the final index seeds the following beat.
    always_comb begin
        beat_data = '0;
        ix        = {1'b0, nxt_start};
        for (int k = 0; k < LANES; k++) begin
            beat_data[k] = sel_pat[ix[SW-1:0]];
            ix = ((ix + LW'(1)) == sel_len) ? '0 : ix + LW'(1);
        end
        beat_end = ix[SW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pat_q      <= '0;
            len_q      <= LW'(1);
            step_q     <= '0;
            dir_q      <= 1'b0;
            x0_q       <= '0;
            y_q        <= '0;
            p_q        <= '0;
            beat_end_q <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_eol      <= 1'b0;
            m_eof      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (clk_en) begin
            case (state)
                S_IDLE: begin
                    if (cfg_load) begin
                        pat_q  <= cfg_pattern;
                        len_q  <= len_c;
                        step_q <= step_c;
                        dir_q  <= cfg_dir;
                    end
                    if (start) begin
                        state      <= S_RUN;
                        busy       <= 1'b1;
                        m_valid    <= 1'b1;
                        x0_q       <= '0;
                        y_q        <= '0;
                        p_q        <= '0;
                        m_data     <= beat_data;
                        beat_end_q <= beat_end;
                        m_eol      <= ONE_BEAT_ROW;
                        m_eof      <= ONE_BEAT_ROW && (IMG_H == 1);
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        m_valid <= 1'b0;
                        m_data  <= '0;
                        m_eol   <= 1'b0;
                        m_eof   <= 1'b0;
                    end else if (m_ready) begin
                        if (m_eof) begin
                            state   <= S_DONE;
                            busy    <= 1'b0;
                            m_valid <= 1'b0;
                            done    <= 1'b1;
                            m_data  <= '0;
                            m_eol   <= 1'b0;
                            m_eof   <= 1'b0;
                        end else if (m_eol) begin
                            x0_q       <= '0;
                            y_q        <= y_q + YW'(1);
                            p_q        <= p_next;
                            m_data     <= beat_data;
                            beat_end_q <= beat_end;
                            m_eol      <= ONE_BEAT_ROW;
                            m_eof      <= ONE_BEAT_ROW && ((y_q + YW'(1)) == Y_LAST);
                        end else begin
                            x0_q       <= x0_q + X_STEP;
                            m_data     <= beat_data;
                            beat_end_q <= beat_end;
                            m_eol      <= ((x0_q + X_STEP) == X_LAST);
                            m_eof      <= ((x0_q + X_STEP) == X_LAST) && (y_q == Y_LAST);
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sliding_mask_gen.sv
// Directed and randomized frames checked against an arithmetic model of
// pixel(x,y) = pattern[(x + p_y) mod len].
module tb_sliding_mask_gen;

    localparam int IMG_W   = 8;
    localparam int IMG_H   = 3;
    localparam int PAT_MAX = 32;
    localparam int LANES   = 4;
    localparam int LW      = $clog2(PAT_MAX) + 1;
    localparam int SW      = $clog2(PAT_MAX);
    localparam int BPR     = IMG_W / LANES;
    localparam int TOTAL   = BPR * IMG_H;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clk_en = 1'b1;
    logic               cfg_load = 1'b0;
    logic [PAT_MAX-1:0] cfg_pattern = '0;
    logic [LW-1:0]      cfg_len = '0;
    logic [SW-1:0]      cfg_step = '0;
    logic               cfg_dir = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [LANES-1:0]   m_data;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic               m_eol;
    logic               m_eof;
    logic               busy;
    logic               done;

    int vectors = 0;
    int miscompares = 0;

    logic [PAT_MAX-1:0] mPat = '0;
    int mLen = 1;
    int mStep = 0;
    int mDir = 0;

    sliding_mask_gen #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PAT_MAX(PAT_MAX), .LANES(LANES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_step(cfg_step),
        .cfg_dir(cfg_dir), .start(start), .abort(abort), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_eol(m_eol), .m_eof(m_eof),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES-1:0] expData(input int b);
        logic [LANES-1:0] r;
        int y, x0, py;
        y  = b / BPR;
        x0 = (b % BPR) * LANES;
        if (mDir == 0) py = (y * mStep) % mLen;
        else           py = (mLen - ((y * mStep) % mLen)) % mLen;
        for (int k = 0; k < LANES; k++)
            r[k] = mPat[(x0 + k + py) % mLen];
        return r;
    endfunction

    // Drives one cycle of configuration/start and mirrors an IDLE cfg_load into the model.
    task automatic applyStimulus(input logic [PAT_MAX-1:0] pat, input int len, input int step,
                                 input int dir, input bit load, input bit st);
        cfg_pattern = pat;
        cfg_len     = LW'(len);
        cfg_step    = SW'(step);
        cfg_dir     = dir[0];
        cfg_load    = load;
        start       = st;
        tick();
        cfg_load = 1'b0;
        start    = 1'b0;
        if (load) begin
            mPat  = pat;
            mLen  = (len == 0) ? 1 : ((len > PAT_MAX) ? PAT_MAX : len);
            mStep = (step >= mLen) ? 0 : step;
            mDir  = dir;
        end
    endtask

    // mode 0: always ready, 1: toggling, 2: random.
    task automatic streamBeats(input int mode, input int nBeats, input int freezeAt, input int noiseAt);
        int beat = 0;
        int cyc = 0;
        int fz = freezeAt;
        while (beat < nBeats && cyc < 400) begin
            cfg_load = 1'b0;
            start    = 1'b0;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 2 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (beat == fz) begin
                fz = -1;
                clk_en  = 1'b0;
                m_ready = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    tick();
                    checkOutput("frz_valid", 32'(m_valid), 32'd1);
                    checkOutput("frz_data", 32'(m_data), 32'(expData(beat)));
                end
                clk_en = 1'b1;
            end
            if (beat == noiseAt) begin
                cfg_load    = 1'b1;
                start       = 1'b1;
                cfg_pattern = ~mPat;
                cfg_len     = LW'(2);
                cfg_dir     = ~mDir[0];
            end
            checkOutput("valid", 32'(m_valid), 32'd1);
            checkOutput("busy", 32'(busy), 32'd1);
            checkOutput("data", 32'(m_data), 32'(expData(beat)));
            checkOutput("eol", 32'(m_eol), 32'((beat % BPR) == BPR - 1));
            checkOutput("eof", 32'(m_eof), 32'(beat == TOTAL - 1));
            if (m_ready) beat++;
            tick();
            cyc++;
        end
        cfg_load = 1'b0;
        start    = 1'b0;
        checkOutput("beat_budget", 32'(beat), 32'(nBeats));
    endtask

    task automatic finishFrame();
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("done_valid", 32'(m_valid), 32'd0);
        checkOutput("done_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("done_clear", 32'(done), 32'd0);
        checkOutput("idle_valid", 32'(m_valid), 32'd0);
    endtask

    initial begin
        #12;
        checkOutput("rst_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_data", 32'(m_data), 32'd0);
        checkOutput("rst_eol", 32'(m_eol), 32'd0);
        checkOutput("rst_eof", 32'(m_eof), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Reset configuration: empty pattern, so an all-zero frame.
        applyStimulus('0, 0, 0, 0, 1'b0, 1'b1);
        streamBeats(0, TOTAL, -1, -1);
        finishFrame();

        // Left slide with load and start together.
        applyStimulus(32'b011, 3, 1, 0, 1'b1, 1'b1);
        checkOutput("l_beat1", 32'(m_data), 32'hB);
        streamBeats(0, TOTAL, -1, -1);
        finishFrame();

        // Right slide, load then start.
        applyStimulus(32'b011, 3, 1, 1, 1'b1, 1'b0);
        checkOutput("idle_after_load", 32'(m_valid), 32'd0);
        applyStimulus(32'b011, 3, 1, 1, 1'b0, 1'b1);
        streamBeats(0, TOTAL, -1, -1);
        finishFrame();

        // Backpressure plus ignored cfg_load/start while running.
        applyStimulus(32'b011, 3, 1, 0, 1'b1, 1'b1);
        streamBeats(1, TOTAL, -1, 2);
        finishFrame();

        // Abort after three transfers, then replay.
        applyStimulus(32'b011, 3, 1, 0, 1'b0, 1'b1);
        streamBeats(0, 3, -1, -1);
        abort   = 1'b1;
        m_ready = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_valid", 32'(m_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        tick();
        checkOutput("abort_done2", 32'(done), 32'd0);
        applyStimulus(32'b011, 3, 1, 0, 1'b0, 1'b1);
        streamBeats(0, TOTAL, -1, -1);
        finishFrame();

        // Clock-enable freeze mid-frame.
        applyStimulus(32'b011, 3, 1, 0, 1'b0, 1'b1);
        streamBeats(0, TOTAL, 3, -1);
        finishFrame();

        // Configuration clamps.
        applyStimulus({$urandom(), 1'b1} >> 0, 0, 3, 0, 1'b1, 1'b1);
        checkOutput("len0_ones", 32'(m_data), 32'hF);
        streamBeats(0, TOTAL, -1, -1);
        finishFrame();
        applyStimulus(PAT_MAX'($urandom()), 40, 7, 1, 1'b1, 1'b1);
        streamBeats(0, TOTAL, -1, -1);
        finishFrame();
        applyStimulus(PAT_MAX'($urandom()), 4, 5, 0, 1'b1, 1'b1);
        streamBeats(0, TOTAL, -1, -1);
        finishFrame();

        // Abort while idle has no effect.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("idle_abort_valid", 32'(m_valid), 32'd0);
        checkOutput("idle_abort_busy", 32'(busy), 32'd0);

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
            applyStimulus(PAT_MAX'($urandom()), int'($urandom_range(0, 40)),
                          int'($urandom_range(0, 31)), int'($urandom_range(0, 1)),
                          1'b1, 1'b1);
            streamBeats(2, TOTAL, -1, -1);
            finishFrame();
        end

        // Reset mid-frame discards the frame and the configuration.
        applyStimulus(32'hFFFF_FFFF, 5, 2, 1, 1'b1, 1'b1);
        streamBeats(0, 2, -1, -1);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(m_valid), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        mPat  = '0;
        mLen  = 1;
        mStep = 0;
        mDir  = 0;
        tick();
        tick();
        checkOutput("post_rst_valid", 32'(m_valid), 32'd0);
        applyStimulus('0, 0, 0, 0, 1'b0, 1'b1);
        streamBeats(0, TOTAL, -1, -1);
        finishFrame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
